nios_base_cpu_jtag_debug_module_scan_master: RTL and testbench

//  Host-side driver for the CPU JTAG debug module's virtual-JTAG port.

---
 rtl/nios_base_cpu_jtag_debug_module_scan_master.sv | 155 +++++++++++++++
 tb/tb_nios_base_cpu_jtag_debug_module_scan_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_base_cpu_jtag_debug_module_scan_master.sv
// Virtual-JTAG scan master: runs one UIR/CDR/SDR/UDR sequence per command and
// returns the tdo bits captured during SDR as a response word.
module nios_base_cpu_jtag_debug_module_scan_master #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RESP} state_e;

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(SR_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      divcnt_q, divcnt_d;
    logic                  tck_q, tck_d;
    logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [SR_WIDTH-1:0]   tx_q, tx_d;
    logic [SR_WIDTH-1:0]   cap_q, cap_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [SR_WIDTH-1:0]   rsp_dr_q, rsp_dr_d;
    logic                  tdi_q, uir_q, cdr_q, sdr_q, udr_q, busy_q;
    logic                  tck_wrap, tck_rise, tck_fall;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        divcnt_d    = divcnt_q;
        tck_d       = tck_q;
        bitcnt_d    = bitcnt_q;
        tx_d        = tx_q;
        cap_d       = cap_q;
        ir_d        = ir_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dr_d    = rsp_dr_q;
        tck_wrap    = (divcnt_q == DIV_LAST);
        tck_rise    = tck_wrap && !tck_q;
        tck_fall    = tck_wrap && tck_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tx_d     = cmd_dr;
                    ir_d     = cmd_ir;
                    bitcnt_d = '0;
                    divcnt_d = '0;
                    tck_d    = 1'b0;
                    state_d  = S_UIR;
                end
            end
            S_UIR, S_CDR, S_SDR, S_UDR: begin
                divcnt_d = tck_wrap ? '0 : divcnt_q + DIV_W'(1);
                if (tck_wrap) tck_d = !tck_q;
                // tdo is sampled as tck rises, so the bit the target drove on the last fall is stable.
                if (state_q == S_SDR && tck_rise) cap_d = {vji_tdo, cap_q[SR_WIDTH-1:1]};
                if (tck_fall) begin
                    if (state_q == S_UIR) begin
                        state_d = S_CDR;
                    end else if (state_q == S_CDR) begin
                        state_d = S_SDR;
                    end else if (state_q == S_SDR) begin
                        tx_d     = {1'b0, tx_q[SR_WIDTH-1:1]};
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                        if (bitcnt_q == BIT_LAST) state_d = S_UDR;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_dr_d    = cap_q;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            divcnt_q    <= '0;
            tck_q       <= 1'b0;
            bitcnt_q    <= '0;
            tx_q        <= '0;
            cap_q       <= '0;
            ir_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dr_q    <= '0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            divcnt_q    <= divcnt_d;
            tck_q       <= tck_d;
            bitcnt_q    <= bitcnt_d;
            tx_q        <= tx_d;
            cap_q       <= cap_d;
            ir_q        <= ir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dr_q    <= rsp_dr_d;
            tdi_q       <= (state_d == S_SDR) ? tx_d[0] : 1'b0;
            uir_q       <= (state_d == S_UIR);
            cdr_q       <= (state_d == S_CDR);
            sdr_q       <= (state_d == S_SDR);
            udr_q       <= (state_d == S_UDR);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign vji_rti   = (state_q == S_IDLE) || (state_q == S_RESP);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dr    = rsp_dr_q;
    assign busy      = busy_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;

endmodule

// File: tb/tb_nios_base_cpu_jtag_debug_module_scan_master.sv
// Bench for the scan master: a behavioural JTAG target (loopback, tied, or
// shift-out of a random word) plus timing expectations computed from the parameters.
module tb_nios_base_cpu_jtag_debug_module_scan_master;

    localparam int SR     = 38;
    localparam int IRW    = 2;
    localparam int DIV    = 2;
    localparam int PERIOD = 2 * DIV;
    localparam int LAT    = (SR + 3) * PERIOD;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [SR-1:0]  cmd_dr = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [SR-1:0]  rsp_dr;
    logic           busy, vji_tck, vji_tdi, vji_tdo, vji_rti;
    logic [IRW-1:0] vji_ir_in;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr;

    int errors = 0;
    int checks = 0;

    // Target model: 0 loopback, 1 tied high, 2 tied low, 3 shifts out resp_word LSB first.
    int            tdo_mode = 0;
    logic [SR-1:0] resp_word = '0;
    logic [SR-1:0] rx_word = '0;
    int            idx = 0;

    nios_base_cpu_jtag_debug_module_scan_master #(
        .SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .busy(busy),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_udr(vji_udr)
    );

    always #5 clk = ~clk;

    always @(posedge vji_cdr) begin
        idx     <= 0;
        rx_word <= '0;
    end

    always @(posedge vji_tck) begin
        if (vji_sdr && idx < SR) begin
            rx_word[idx] <= vji_tdi;
            idx          <= idx + 1;
        end
    end

    always_comb begin
        vji_tdo = 1'b0;
        case (tdo_mode)
            0: vji_tdo = vji_tdi;
            1: vji_tdo = 1'b1;
            2: vji_tdo = 1'b0;
            default: vji_tdo = (idx < SR) ? resp_word[idx] : 1'b0;
        endcase
    end

    // {cmd_ready, rsp_valid, busy, tck, tdi, rti, uir, cdr, sdr, udr}
    localparam logic [9:0] IDLE_OUTS = 10'b1_0_0_0_0_1_0_0_0_0;
    function automatic logic [9:0] ctrl_outs();
        return {cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_rti,
                vji_uir, vji_cdr, vji_sdr, vji_udr};
    endfunction

    function automatic logic [SR-1:0] expected_rsp(input int mode, input logic [SR-1:0] dr);
        case (mode)
            0: return dr;
            1: return '1;
            2: return '0;
            default: return resp_word;
        endcase
    endfunction

    task automatic run_scan(input string name, input logic [IRW-1:0] ir, input logic [SR-1:0] dr,
                            input int mode, input int hold);
        int k, n_uir, n_cdr, n_sdr, n_udr, f_cdr, f_sdr, f_udr, rises, ir_bad, bp_bad;
        logic prev_tck;
        logic [SR-1:0] exp_rsp;
        exp_rsp = expected_rsp(mode, dr);
        tdo_mode = mode;
        @(negedge clk);
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1; rsp_ready = 1'b0;
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
        checks++;
        if (!cmd_ready) begin
            errors++; $display("FAIL %s accept: cmd_ready=%b want 1", name, cmd_ready);
            cmd_valid = 1'b0; return;
        end
        @(negedge clk);
        // Garbage offered while busy must be ignored.
        cmd_ir = ~ir; cmd_dr = ~dr;
        k = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
        f_cdr = -1; f_sdr = -1; f_udr = -1; rises = 0; ir_bad = 0; prev_tck = 1'b0;
        while (!rsp_valid && k < LAT + 50) begin
            if (vji_uir) n_uir++;
            if (vji_cdr) begin n_cdr++; if (f_cdr < 0) f_cdr = k; end
            if (vji_sdr) begin n_sdr++; if (f_sdr < 0) f_sdr = k; end
            if (vji_udr) begin n_udr++; if (f_udr < 0) f_udr = k; end
            if (vji_tck && !prev_tck) rises++;
            prev_tck = vji_tck;
            if (vji_ir_in !== ir) ir_bad++;
            @(negedge clk); k++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (k != LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, k, LAT); end
        checks++;
        if ({n_uir, n_cdr, n_sdr, n_udr} != {PERIOD, PERIOD, SR * PERIOD, PERIOD}) begin
            errors++;
            $display("FAIL %s strobe_len: got uir=%0d cdr=%0d sdr=%0d udr=%0d want %0d/%0d/%0d/%0d",
                     name, n_uir, n_cdr, n_sdr, n_udr, PERIOD, PERIOD, SR * PERIOD, PERIOD);
        end
        checks++;
        if ({f_cdr, f_sdr, f_udr} != {PERIOD, 2 * PERIOD, (SR + 2) * PERIOD}) begin
            errors++;
            $display("FAIL %s strobe_order: got cdr@%0d sdr@%0d udr@%0d want %0d/%0d/%0d",
                     name, f_cdr, f_sdr, f_udr, PERIOD, 2 * PERIOD, (SR + 2) * PERIOD);
        end
        checks++;
        if (rises != SR + 3) begin errors++; $display("FAIL %s tck_rises: got %0d want %0d", name, rises, SR + 3); end
        checks++;
        if (ir_bad != 0) begin errors++; $display("FAIL %s ir_in: got %0d bad cycles want 0", name, ir_bad); end
        checks++;
        if (rx_word !== dr || idx != SR) begin
            errors++; $display("FAIL %s tdi_stream: got %h (%0d bits) want %h (%0d bits)", name, rx_word, idx, dr, SR);
        end
        checks++;
        if (rsp_dr !== exp_rsp) begin errors++; $display("FAIL %s rsp_dr: got %h want %h", name, rsp_dr, exp_rsp); end
        bp_bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dr !== exp_rsp || cmd_ready !== 1'b0 || vji_tck !== 1'b0 || busy !== 1'b1)
                bp_bad++;
            @(negedge clk);
        end
        if (hold > 0) begin
            checks++;
            if (bp_bad != 0) begin errors++; $display("FAIL %s backpressure: got %0d bad cycles want 0", name, bp_bad); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (ctrl_outs() !== IDLE_OUTS) begin
            errors++; $display("FAIL %s return_idle: got %b want %b", name, ctrl_outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctrl_outs() !== IDLE_OUTS || vji_ir_in !== '0 || rsp_dr !== '0) begin
            errors++; $display("FAIL reset_state: got %b ir=%b rsp=%h want %b ir=0 rsp=0",
                               ctrl_outs(), vji_ir_in, rsp_dr, IDLE_OUTS);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_outs() !== IDLE_OUTS) begin
            errors++; $display("FAIL reset_release: got %b want %b", ctrl_outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_directed();
        run_scan("loopback", 2'b01, 38'h2A_DEAD_BEEF, 0, 0);
        run_scan("tdo_high", 2'b00, '0, 1, 0);
        run_scan("tdo_low", 2'b11, 38'h15_5555_5555, 2, 0);
        run_scan("backpressure", 2'b10, 38'h01_2345_6789, 0, 10);
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [SR-1:0] dr;
        for (int n = 0; n < 6; n++) begin
            r = {$urandom(), $urandom()}; dr = r[SR-1:0];
            r = {$urandom(), $urandom()}; resp_word = r[SR-1:0];
            run_scan("random", IRW'($urandom_range(0, 3)), dr, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_reset_mid_scan();
        int k;
        tdo_mode = 0;
        @(negedge clk);
        cmd_ir = 2'b11; cmd_dr = 38'h3A_5A5A_5A5A; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(vji_sdr && idx == 20) && k < 1000) begin @(negedge clk); k++; end
        checks++;
        if (!(vji_sdr && idx == 20)) begin errors++; $display("FAIL midscan_reach: got sdr=%b idx=%0d want 1/20", vji_sdr, idx); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctrl_outs() !== IDLE_OUTS || vji_ir_in !== '0 || rsp_dr !== '0) begin
            errors++; $display("FAIL midscan_reset: got %b ir=%b rsp=%h want %b ir=0 rsp=0",
                               ctrl_outs(), vji_ir_in, rsp_dr, IDLE_OUTS);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midscan_no_rsp: got rsp_valid=%b want 0", rsp_valid); end
        run_scan("after_reset", 2'b01, 38'h0F_0F0F_0F0F, 0, 0);
    endtask

    task automatic test_back_to_back();
        int k;
        tdo_mode = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_ir = 2'b10; cmd_dr = 38'h11_1111_1111; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_ir = 2'b11; cmd_dr = 38'h22_2222_2222;
        k = 0;
        while (!rsp_valid && k < LAT + 50) begin @(negedge clk); k++; end
        checks++;
        if (k != LAT || rsp_dr !== 38'h11_1111_1111 || vji_ir_in !== 2'b10) begin
            errors++; $display("FAIL b2b_first: got lat=%0d rsp=%h ir=%b want %0d %h 10",
                               k, rsp_dr, vji_ir_in, LAT, 38'h11_1111_1111);
        end
        while (!cmd_ready && k < LAT + 50) begin @(negedge clk); k++; end
        checks++;
        if (k != LAT + 1) begin errors++; $display("FAIL b2b_idle: got %0d want %0d", k, LAT + 1); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || vji_ir_in !== 2'b11) begin
            errors++; $display("FAIL b2b_accept: got ready=%b ir=%b want 0 11", cmd_ready, vji_ir_in);
        end
        k = 0;
        while (!rsp_valid && k < LAT + 50) begin @(negedge clk); k++; end
        checks++;
        if (k != LAT || rsp_dr !== 38'h22_2222_2222) begin
            errors++; $display("FAIL b2b_second: got lat=%0d rsp=%h want %0d %h", k, rsp_dr, LAT, 38'h22_2222_2222);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (ctrl_outs() !== IDLE_OUTS) begin errors++; $display("FAIL b2b_idle_end: got %b want %b", ctrl_outs(), IDLE_OUTS); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
